hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single pipeline clock, rising-edge active.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port ir_d, input, 32 bits: the D-stage instruction word.
REQ-004 SHALL have port stall, output, 1 bit: high means the D instruction cannot get its operands by forwarding.
REQ-005 SHALL have port en_pc, output, 1 bit: PC write enable; equals ~stall.
REQ-006 SHALL have port en_d, output, 1 bit: F/D register enable; equals ~stall.
REQ-007 SHALL have port clr_e, output, 1 bit: D/E register clear (bubble insert); equals stall.
REQ-008 SHALL have port stall_cnt, output, 16 bits: count of stall cycles since reset.

Function
REQ-009 SHALL decode ir_d internally using: op [31:26], func [5:0], rs [25:21], rt [20:16], rd [15:11].
REQ-010 SHALL recognise addu (op 000000, func 100001) and subu (op 000000, func 100011).
REQ-011 SHALL recognise jr (op 000000, func 001000), ori (001101), lui (001111), lw (100011), sw (101011), beq (000100), j (000010) and jal (000011).
REQ-012 SHALL treat every other encoding as a nop: no source reads, no destination.
REQ-013 SHALL assign Tuse(rs) = 0 for beq and jr; 1 for addu, subu, ori, lw and sw.
REQ-014 SHALL assign Tuse(rt) = 0 for beq, 1 for addu and subu, 2 for sw.
REQ-015 SHALL treat rt as not read for ori, lui, lw, jr, j and jal, and rs as not read for lui, j and jal.
REQ-016 SHALL assign destination and Tnew-at-E as: addu/subu -> rd, 1; ori/lui -> rt, 1; lw -> rt, 2; jal -> 31, 0; all others -> none.
REQ-017 SHALL hold three registered slots, E, M and W, each with valid (1b), dst (5b) and tnew (2b).
REQ-018 SHALL, on every clk edge with stall low, load slot E from the decoded ir_d (valid = has destination and dst != 0).
REQ-019 SHALL, on every clk edge with stall high, load slot E with a bubble (valid = 0).
REQ-020 SHALL, on every clk edge regardless of stall, copy E to M and M to W, decrementing tnew by 1 and saturating at 0.
REQ-021 SHALL discard the old W slot on each edge.
REQ-022 SHALL compute stall combinationally from the current slots and ir_d only.
REQ-023 SHALL assert stall when any valid slot has dst == rs(ir_d), rs is read, rs != 0, and slot tnew > Tuse(rs).
REQ-024 SHALL assert stall under the same condition applied to rt.
REQ-025 SHALL never stall on register $0, whether as source or destination.
REQ-026 SHALL, when several slots match the same register, still stall whenever any single matching slot violates its condition.
REQ-027 SHALL increment stall_cnt on each clk edge with stall high.
REQ-028 SHALL hold stall_cnt at 16'hFFFF once reached, with no wrap-around.
REQ-029 SHALL give a one-cycle stall each time a dependent instruction is re-presented unchanged, because ir_d is held by en_d = 0; the stall releases once the slot tnew has decayed.

Reset
REQ-030 SHALL, while reset = 0, clear all slot valid, dst and tnew fields and stall_cnt to 0, asynchronously and regardless of clk.
REQ-031 SHALL therefore drive stall = 0, en_pc = 1, en_d = 1 and clr_e = 0 during reset.
REQ-032 SHALL, on reset deassertion mid-sequence, discard all in-flight dependencies, so the next ir_d sees no hazard.

Verification
REQ-033 SHALL pass: lw $1,0($0) then addu $2,$1,$3 -> exactly 1 stall cycle, then stall_cnt = 1.
REQ-034 SHALL pass: lw $1 then beq $1,$0 -> stall for 2 consecutive cycles; addu $1 then beq $1,$0 -> 1 stall cycle.
REQ-035 SHALL pass: lw $1 then sw $1,0($2) (rt dependence) -> 0 stalls; lw $1 then sw $2,0($1) (rs dependence) -> 1 stall.
REQ-036 SHALL pass: jal then jr $31 -> 0 stalls; ori $0,$0,5 then beq $0,$0 -> 0 stalls.
REQ-037 SHALL pass: lw $1 issued, reset pulsed low, then addu $2,$1,$1 -> stall = 0 and stall_cnt = 0.
REQ-038 SHALL pass: 70000 back-to-back lw/beq dependent pairs -> stall_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Stall-based hazard detection for a 5-stage MIPS-like pipeline: tracks pending
// register writes in E/M/W and stalls the D-stage instruction when forwarding cannot help.
module hazard_scoreboard (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_d,
  output logic        stall,
  output logic        en_pc,
  output logic        en_d,
  output logic        clr_e,
  output logic [15:0] stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  logic [5:0] op;
  logic [5:0] func;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_shamt;

  assign op           = ir_d[31:26];
  assign func         = ir_d[5:0];
  assign rs           = ir_d[25:21];
  assign rt           = ir_d[20:16];
  assign rd           = ir_d[15:11];
  assign unused_shamt = ^ir_d[10:6];

  logic       rs_read;
  logic       rt_read;
  logic [1:0] tuse_rs;
  logic [1:0] tuse_rt;
  logic       has_dst;
  logic [4:0] dst_next;
  logic [1:0] tnew_next;

  // Unrecognised encodings fall through the defaults and behave as a nop.
  always_comb begin
    rs_read   = 1'b0;
    rt_read   = 1'b0;
    tuse_rs   = 2'd0;
    tuse_rt   = 2'd0;
    has_dst   = 1'b0;
    dst_next  = 5'd0;
    tnew_next = 2'd0;
    case (op)
      OP_RTYPE: begin
        if (func == FN_ADDU || func == FN_SUBU) begin
          rs_read   = 1'b1;
          rt_read   = 1'b1;
          tuse_rs   = 2'd1;
          tuse_rt   = 2'd1;
          has_dst   = 1'b1;
          dst_next  = rd;
          tnew_next = 2'd1;
        end else if (func == FN_JR) begin
          rs_read = 1'b1;
          tuse_rs = 2'd0;
        end
      end
      OP_ORI: begin
        rs_read   = 1'b1;
        tuse_rs   = 2'd1;
        has_dst   = 1'b1;
        dst_next  = rt;
        tnew_next = 2'd1;
      end
      OP_LUI: begin
        has_dst   = 1'b1;
        dst_next  = rt;
        tnew_next = 2'd1;
      end
      OP_LW: begin
        rs_read   = 1'b1;
        tuse_rs   = 2'd1;
        has_dst   = 1'b1;
        dst_next  = rt;
        tnew_next = 2'd2;
      end
      OP_SW: begin
        rs_read = 1'b1;
        rt_read = 1'b1;
        tuse_rs = 2'd1;
        tuse_rt = 2'd2;
      end
      OP_BEQ: begin
        rs_read = 1'b1;
        rt_read = 1'b1;
        tuse_rs = 2'd0;
        tuse_rt = 2'd0;
      end
      OP_JAL: begin
        has_dst   = 1'b1;
        dst_next  = 5'd31;
        tnew_next = 2'd0;
      end
      OP_J:    ;
      default: ;
    endcase
  end

  // Slot index 0 = E, 1 = M, 2 = W.
  logic [2:0] slot_valid_reg;
  logic [4:0] slot_dst_reg  [3];
  logic [1:0] slot_tnew_reg [3];
  logic [2:0] rs_hit;
  logic [2:0] rt_hit;
  logic [15:0] stall_cnt_reg;

  for (genvar gi = 0; gi < 3; gi++) begin : g_hazard
    assign rs_hit[gi] = slot_valid_reg[gi] && rs_read && (rs != 5'd0) &&
                        (slot_dst_reg[gi] == rs) && (slot_tnew_reg[gi] > tuse_rs);
    assign rt_hit[gi] = slot_valid_reg[gi] && rt_read && (rt != 5'd0) &&
                        (slot_dst_reg[gi] == rt) && (slot_tnew_reg[gi] > tuse_rt);
  end

  assign stall     = (|rs_hit) || (|rt_hit);
  assign en_pc     = ~stall;
  assign en_d      = ~stall;
  assign clr_e     = stall;
  assign stall_cnt = stall_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_valid_reg <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        slot_dst_reg[i]  <= 5'd0;
        slot_tnew_reg[i] <= 2'd0;
      end
      stall_cnt_reg <= 16'd0;
    end else begin
      // A stalled D instruction enters E as a bubble; writes to $0 are never tracked.
      slot_valid_reg[0] <= !stall && has_dst && (dst_next != 5'd0);
      slot_dst_reg[0]   <= stall ? 5'd0 : dst_next;
      slot_tnew_reg[0]  <= stall ? 2'd0 : tnew_next;
      for (int i = 1; i < 3; i++) begin
        slot_valid_reg[i] <= slot_valid_reg[i-1];
        slot_dst_reg[i]   <= slot_dst_reg[i-1];
        slot_tnew_reg[i]  <= (slot_tnew_reg[i-1] == 2'd0) ? 2'd0 : slot_tnew_reg[i-1] - 2'd1;
      end
      if (stall && (stall_cnt_reg != 16'hFFFF))
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

endmodule
